// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_e;

   localparam logic [4:0]  REG_ZERO  = 5'd0;
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   // A load in EX feeding a source register read in ID; x0 never counts.
   function automatic logic load_use_hazard(
      input logic       ex_memread,
      input logic [4:0] ex_rd,
      input logic [4:0] id_rs1,
      input logic [4:0] id_rs2,
      input logic       id_use_rs1,
      input logic       id_use_rs2
   );
      return ex_memread && (ex_rd != REG_ZERO) &&
             ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));
   endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) count_d = count_q + W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencing for the 5-stage core: memory waits, taken branches
// and load-use hazards, plus saturating performance counters.
module pipeline_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rd,
   input  logic             mem_branch,
   input  logic             mem_zero,
   input  logic             mem_memread,
   input  logic             mem_memwrite,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             pc_src,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_write,
   output logic             ex_mem_flush,
   output logic             mem_wb_bubble,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

   state_e     state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       mem_timeout_q, mem_timeout_d;
   logic       mem_access, load_use;
   logic       mem_stall, taken, lu_stall;

   assign mem_access = mem_memread | mem_memwrite;
   assign load_use   = load_use_hazard(ex_memread, ex_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2);

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      mem_stall     = 1'b0;
      taken         = 1'b0;
      lu_stall      = 1'b0;

      // Memory wait outranks branches, which outrank load-use.
      if (state_q == RUN) begin
         if (mem_access && !dmem_ready) begin
            mem_stall  = 1'b1;
            state_d    = MEM_WAIT;
            wait_cnt_d = 8'd1;
         end else if (mem_branch && mem_zero) begin
            taken = 1'b1;
         end else if (load_use) begin
            lu_stall = 1'b1;
         end
      end else begin
         mem_stall = 1'b1;
         if (dmem_ready) begin
            state_d    = RUN;
            wait_cnt_d = 8'd0;
         end else if (wait_cnt_q != TIMEOUT_CNT) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
         end
      end

      if ((state_d == MEM_WAIT) && (wait_cnt_d == TIMEOUT_CNT)) mem_timeout_d = 1'b1;
   end

   // Outputs are held at their idle values while reset is asserted.
   always_comb begin
      pc_write      = 1'b1;
      pc_src        = 1'b0;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_write  = 1'b1;
      ex_mem_flush  = 1'b0;
      mem_wb_bubble = 1'b0;
      if (reset) begin
         if (mem_stall) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
         end else if (taken) begin
            pc_src       = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
         end else if (lu_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= RUN;
         wait_cnt_q    <= 8'd0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   assign mem_timeout = mem_timeout_q;

   hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (!pc_write),
      .count (stall_cycles)
   );

   hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (reset && taken),
      .count (flush_count)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized bench for pipeline_hazard_ctrl against a rule-level model.
module tb_pipeline_hazard_ctrl;

   localparam int MT    = 4;
   localparam int CNT_W = 8;
   localparam int CMAX  = (1 << CNT_W) - 1;

   // Output vector {pc_write,pc_src,if_id_write,if_id_flush,id_ex_flush,ex_mem_write,ex_mem_flush,mem_wb_bubble}
   localparam logic [7:0] O_IDLE = 8'hA4;
   localparam logic [7:0] O_MEM  = 8'h01;
   localparam logic [7:0] O_BR   = 8'hFE;
   localparam logic [7:0] O_LU   = 8'h0C;

   logic clk, reset;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic id_use_rs1, id_use_rs2, ex_memread, mem_branch, mem_zero;
   logic mem_memread, mem_memwrite, dmem_ready;
   logic pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush;
   logic ex_mem_write, ex_mem_flush, mem_wb_bubble, mem_timeout;
   logic [CNT_W-1:0] stall_cycles, flush_count;
   logic [7:0] outs;

   int errors = 0;
   int checks = 0;

   bit m_wait, m_to;
   int m_wcnt, m_stall, m_flush;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memread(ex_memread),
      .ex_rd(ex_rd), .mem_branch(mem_branch), .mem_zero(mem_zero),
      .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .dmem_ready(dmem_ready),
      .pc_write(pc_write), .pc_src(pc_src), .if_id_write(if_id_write),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_write(ex_mem_write),
      .ex_mem_flush(ex_mem_flush), .mem_wb_bubble(mem_wb_bubble), .mem_timeout(mem_timeout),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   assign outs = {pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush,
                  ex_mem_write, ex_mem_flush, mem_wb_bubble};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] exp_outs();
      if (!reset) return O_IDLE;
      if (m_wait || ((mem_memread || mem_memwrite) && !dmem_ready)) return O_MEM;
      if (mem_branch && mem_zero) return O_BR;
      if (ex_memread && ex_rd != 5'd0 &&
          ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2))) return O_LU;
      return O_IDLE;
   endfunction

   task automatic model_reset();
      m_wait = 0; m_to = 0; m_wcnt = 0; m_stall = 0; m_flush = 0;
   endtask

   task automatic model_update();
      logic [7:0] o;
      if (!reset) begin
         model_reset();
         return;
      end
      o = exp_outs();
      if (!o[7] && m_stall < CMAX) m_stall++;
      if (o == O_BR && m_flush < CMAX) m_flush++;
      if (!m_wait) begin
         if ((mem_memread || mem_memwrite) && !dmem_ready) begin
            m_wait = 1; m_wcnt = 1;
         end
      end else if (dmem_ready) begin
         m_wait = 0; m_wcnt = 0;
      end else begin
         m_wcnt++;
      end
      if (m_wait && m_wcnt >= MT) m_to = 1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      ex_memread = 0; mem_branch = 0; mem_zero = 0;
      mem_memread = 0; mem_memwrite = 0; dmem_ready = 1;
   endtask

   task automatic test_reset();
      // Hazard-looking inputs must not leak through while reset is low.
      ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
      mem_memread = 1; dmem_ready = 0; mem_branch = 1; mem_zero = 1;
      #1;
      checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL reset_outs: got %h want %h", outs, O_IDLE); end
      checks++; if (stall_cycles !== 0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
      checks++; if (flush_count !== 0) begin errors++; $display("FAIL reset_flush: got %0d want 0", flush_count); end
      checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", mem_timeout); end
      next_cycle();
      #1;
      checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL reset_hold_outs: got %h want %h", outs, O_IDLE); end
      clear_inputs();
      reset = 1'b1;
      next_cycle();
   endtask

   task automatic test_load_use();
      ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
      #1;
      checks++; if (outs !== O_LU) begin errors++; $display("FAIL lu_outs: got %h want %h", outs, O_LU); end
      checks++; if (stall_cycles !== 0) begin errors++; $display("FAIL lu_stall_before: got %0d want 0", stall_cycles); end
      next_cycle();
      ex_memread = 0;
      #1;
      checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL lu_release: got %h want %h", outs, O_IDLE); end
      checks++; if (stall_cycles !== 1) begin errors++; $display("FAIL lu_stall_after: got %0d want 1", stall_cycles); end
      clear_inputs();
      next_cycle();
   endtask

   task automatic test_filter();
      ex_memread = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
      #1;
      checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL x0_filter: got %h want %h", outs, O_IDLE); end
      next_cycle();
      ex_rd = 7; id_rs2 = 7; id_use_rs1 = 0; id_use_rs2 = 0;
      #1;
      checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL unused_rs2: got %h want %h", outs, O_IDLE); end
      id_use_rs2 = 1;
      #1;
      checks++; if (outs !== O_LU) begin errors++; $display("FAIL rs2_hazard: got %h want %h", outs, O_LU); end
      id_use_rs2 = 0;
      next_cycle();
      #1;
      checks++; if (stall_cycles !== 1) begin errors++; $display("FAIL filter_stall: got %0d want 1", stall_cycles); end
      clear_inputs();
   endtask

   task automatic test_branch();
      mem_branch = 1; mem_zero = 1;
      ex_memread = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
      #1;
      checks++; if (outs !== O_BR) begin errors++; $display("FAIL br_taken: got %h want %h", outs, O_BR); end
      next_cycle();
      clear_inputs();
      #1;
      checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL br_after: got %h want %h", outs, O_IDLE); end
      checks++; if (flush_count !== 1) begin errors++; $display("FAIL br_count: got %0d want 1", flush_count); end
      checks++; if (stall_cycles !== 1) begin errors++; $display("FAIL br_no_stall: got %0d want 1", stall_cycles); end
      mem_branch = 1; mem_zero = 0;
      #1;
      checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL br_not_taken: got %h want %h", outs, O_IDLE); end
      next_cycle();
      #1;
      checks++; if (flush_count !== 1) begin errors++; $display("FAIL br_nt_count: got %0d want 1", flush_count); end
      clear_inputs();
   endtask

   task automatic test_mem_wait();
      mem_memread = 1; dmem_ready = 0;
      for (int i = 0; i < 4; i++) begin
         if (i == 1) begin ex_memread = 1; ex_rd = 9; id_rs2 = 9; id_use_rs2 = 1; end
         if (i == 3) dmem_ready = 1;
         #1;
         checks++; if (outs !== O_MEM) begin errors++; $display("FAIL memwait_c%0d: got %h want %h", i, outs, O_MEM); end
         next_cycle();
      end
      ex_memread = 0;
      #1;
      checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL memwait_done: got %h want %h", outs, O_IDLE); end
      checks++; if (stall_cycles !== 5) begin errors++; $display("FAIL memwait_stall: got %0d want 5", stall_cycles); end
      checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL memwait_timeout: got %b want 0", mem_timeout); end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_timeout();
      mem_memwrite = 1; dmem_ready = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         checks++; if (outs !== O_MEM) begin errors++; $display("FAIL to_outs_c%0d: got %h want %h", i, outs, O_MEM); end
         checks++; if (mem_timeout !== (i >= MT)) begin errors++; $display("FAIL to_flag_c%0d: got %b want %b", i, mem_timeout, (i >= MT)); end
         next_cycle();
      end
      dmem_ready = 1;
      #1;
      checks++; if (outs !== O_MEM) begin errors++; $display("FAIL to_ready_hold: got %h want %h", outs, O_MEM); end
      next_cycle();
      #1;
      checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL to_back_run: got %h want %h", outs, O_IDLE); end
      checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", mem_timeout); end
      checks++; if (stall_cycles !== CNT_W'(m_stall)) begin errors++; $display("FAIL to_stall: got %0d want %0d", stall_cycles, m_stall); end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_reset_mid_stall();
      mem_memread = 1; dmem_ready = 0;
      next_cycle();
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL rst_mid_outs: got %h want %h", outs, O_IDLE); end
      checks++; if (stall_cycles !== 0 || flush_count !== 0) begin errors++; $display("FAIL rst_mid_cnt: got %0d/%0d want 0/0", stall_cycles, flush_count); end
      checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL rst_mid_timeout: got %b want 0", mem_timeout); end
      next_cycle();
      reset = 1'b1;
      dmem_ready = 1;
      #1;
      checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL rst_release_run: got %h want %h", outs, O_IDLE); end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_random();
      for (int i = 0; i < 1000; i++) begin
         id_rs1 = 5'($urandom_range(0, 3));
         id_rs2 = 5'($urandom_range(0, 3));
         ex_rd = 5'($urandom_range(0, 3));
         id_use_rs1 = 1'($urandom_range(0, 1));
         id_use_rs2 = 1'($urandom_range(0, 1));
         ex_memread = 1'($urandom_range(0, 1));
         mem_branch = ($urandom_range(0, 3) == 0);
         mem_zero = 1'($urandom_range(0, 1));
         mem_memread = ($urandom_range(0, 9) == 0);
         mem_memwrite = ($urandom_range(0, 12) == 0);
         dmem_ready = ($urandom_range(0, 9) < 6);
         #1;
         checks++; if (outs !== exp_outs()) begin errors++; $display("FAIL rnd_outs_c%0d: got %h want %h", i, outs, exp_outs()); end
         checks++; if (stall_cycles !== CNT_W'(m_stall)) begin errors++; $display("FAIL rnd_stall_c%0d: got %0d want %0d", i, stall_cycles, m_stall); end
         checks++; if (flush_count !== CNT_W'(m_flush)) begin errors++; $display("FAIL rnd_flush_c%0d: got %0d want %0d", i, flush_count, m_flush); end
         checks++; if (mem_timeout !== m_to) begin errors++; $display("FAIL rnd_timeout_c%0d: got %b want %b", i, mem_timeout, m_to); end
         next_cycle();
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      model_reset();
      reset = 1'b1;
      #1 reset = 1'b0;
      @(negedge clk);
      test_reset();
      test_load_use();
      test_filter();
      test_branch();
      test_mem_wait();
      test_timeout();
      test_reset_mid_stall();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
